gate_tt_checker: RTL and testbench

- Clocked stimulus/checker stage for two-input switch-level gate models (CMOS OR, AND, NAND, NOR cells).
- Sits directly upstream and downstream of the gate under test:
  - drives its `a`/`b` inputs through all four input combinations;
  - waits a programmable settle time;
  - samples the gate output and compares it with an expected truth table.
- Reports per-vector failures, X/Z detection and an overall pass flag.
- Replaces hand-written `#10` stimulus blocks in gate benches with a reusable, synthesizable-style sequencer.

---
 rtl/gate_tt_checker.sv | 121 ++++++++++++
 tb/tb_gate_tt_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_checker.sv
// Stimulus/checker sequencer for two-input gate models: sweeps {a,b} through 00..11,
// waits a settle time per vector, and compares the sampled output against a truth table.
`timescale 1ns/1ps
module gate_tt_checker #(
  parameter logic [3:0] EXPECTED_TT   = 4'b1110,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_out,
  output logic       a,
  output logic       b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic       xz_seen,
  output logic [1:0] dbg_state
);

  localparam int              S_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(S_EFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_vec_idx;
  logic             r_pass;
  logic [3:0]       r_fail_mask;
  logic             r_xz_seen;

  logic             w_sample;
  logic             w_last;
  logic             w_is_xz;
  logic             w_mismatch;
  logic [3:0]       w_fail_next;

  // Case (in)equality so that X and Z on the gate output count as failures.
  assign w_sample    = (r_state == ST_SETTLE) && (r_cnt == '0);
  assign w_last      = (r_vec_idx == 2'd3);
  assign w_is_xz     = (gate_out !== 1'b0) && (gate_out !== 1'b1);
  assign w_mismatch  = (gate_out !== EXPECTED_TT[r_vec_idx]);
  assign w_fail_next = r_fail_mask | (w_mismatch ? (4'b0001 << r_vec_idx) : 4'b0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_SETTLE;
      ST_SETTLE: if (w_sample && w_last) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_vec_idx   <= 2'd0;
      r_pass      <= 1'b0;
      r_fail_mask <= 4'b0000;
      r_xz_seen   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_vec_idx   <= 2'd0;
            r_cnt       <= RELOAD;
            r_fail_mask <= 4'b0000;
            r_xz_seen   <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_fail_mask <= w_fail_next;
            r_xz_seen   <= r_xz_seen | w_is_xz;
            if (w_last) begin
              r_vec_idx <= 2'd0;
              r_pass    <= (w_fail_next == 4'b0000);
            end else begin
              // Next vector is applied on the sampling edge: no gap between vectors.
              r_vec_idx <= r_vec_idx + 2'd1;
              r_cnt     <= RELOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // vec_idx is forced back to 0 outside SETTLE, so a/b follow it directly.
  always_comb begin
    busy      = (r_state == ST_SETTLE);
    done      = (r_state == ST_DONE);
    vec_idx   = r_vec_idx;
    a         = r_vec_idx[1];
    b         = r_vec_idx[0];
    pass      = r_pass;
    fail_mask = r_fail_mask;
    xz_seen   = r_xz_seen;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: three instances (settle 4, settle 2, settle 0 with NAND table)
// driven by simple gate models; sweep results go through an expected-value queue.
`timescale 1ns/1ps
module tb_gate_tt_checker;

  localparam int         N       = 3;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam int         S_V[N]  = '{4, 2, 1};
  localparam int M_OR = 0, M_AND = 1, M_NAND = 2, M_DLY = 3, M_Z = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_v[N];
  logic [2:0] mode_v[N];
  logic [2:0] dly_v[N];
  logic       a_v[N], b_v[N], busy_v[N], done_v[N], pass_v[N], xz_v[N];
  logic [1:0] idx_v[N], st_v[N];
  logic [3:0] fm_v[N];
  wire        g0, g1, g2;

  logic [5:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- gate models ----------------
  function automatic logic gmodel(input logic [2:0] m, input logic ia, input logic ib, input logic d);
    case (m)
      3'(M_AND):  return ia & ib;
      3'(M_NAND): return ~(ia & ib);
      3'(M_DLY):  return d;
      default:    return ia | ib;
    endcase
  endfunction

  // Three-stage pipe of a|b: the model output lags its inputs by three clocks.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_n) dly_v[k] <= 3'b000;
      else        dly_v[k] <= {dly_v[k][1:0], a_v[k] | b_v[k]};
    end
  end

  assign g0 = (mode_v[0] == 3'(M_Z)) ? 1'bz : gmodel(mode_v[0], a_v[0], b_v[0], dly_v[0][2]);
  assign g1 = (mode_v[1] == 3'(M_Z)) ? 1'bz : gmodel(mode_v[1], a_v[1], b_v[1], dly_v[1][2]);
  assign g2 = (mode_v[2] == 3'(M_Z)) ? 1'bz : gmodel(mode_v[2], a_v[2], b_v[2], dly_v[2][2]);

  gate_tt_checker u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .gate_out(g0),
    .a(a_v[0]), .b(b_v[0]), .vec_idx(idx_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .fail_mask(fm_v[0]), .xz_seen(xz_v[0]), .dbg_state(st_v[0])
  );

  gate_tt_checker #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .gate_out(g1),
    .a(a_v[1]), .b(b_v[1]), .vec_idx(idx_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .fail_mask(fm_v[1]), .xz_seen(xz_v[1]), .dbg_state(st_v[1])
  );

  gate_tt_checker #(.EXPECTED_TT(TT_NAND), .SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .gate_out(g2),
    .a(a_v[2]), .b(b_v[2]), .vec_idx(idx_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .fail_mask(fm_v[2]), .xz_seen(xz_v[2]), .dbg_state(st_v[2])
  );

  // ---------------- helpers ----------------
  function automatic logic probe(input int k);
    case (k)
      0:       return g0;
      1:       return g1;
      default: return g2;
    endcase
  endfunction

  function automatic logic [3:0] tt_of(input int k);
    return (k == 2) ? TT_NAND : TT_OR;
  endfunction

  function automatic logic [5:0] res(input int k);
    return {pass_v[k], xz_v[k], fm_v[k]};
  endfunction

  function automatic logic [15:0] all_out(input int k);
    return {a_v[k], b_v[k], idx_v[k], busy_v[k], done_v[k], res(k), st_v[k]};
  endfunction

  // Expected result for a constant gate output, whatever the simulator makes of Z.
  function automatic logic [5:0] const_expect(input int k);
    logic       g;
    logic [3:0] m;
    logic [3:0] tt;
    g  = probe(k);
    tt = tt_of(k);
    if ($isunknown(g)) return {1'b0, 1'b1, 4'b1111};
    for (int i = 0; i < 4; i++) m[i] = (g != tt[i]);
    return {(m == 4'b0000), 1'b0, m};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 100 && (busy_v[k] || done_v[k]); i++) @(negedge clk);
  endtask

  // ---------------- driver ----------------
  // Starts a sweep on instance k and follows it edge by edge; start is re-pulsed
  // after edge restart_at (0 = never) to show it is ignored while busy.
  task automatic run_sweep(input int k, input int mode, input int restart_at,
                           input logic [5:0] exp, input bit use_const);
    int         s;
    int         seq_err;
    int         ei;
    logic [5:0] got_exp;
    s       = S_V[k];
    seq_err = 0;
    drain(k);
    @(negedge clk);
    mode_v[k] = 3'(mode);
    #1;
    exp_q.push_back(use_const ? const_expect(k) : exp);
    start_v[k] = 1'b1;
    for (int n = 1; n <= 4 * s + 1; n++) begin
      @(posedge clk);
      @(negedge clk);
      start_v[k] = (n == restart_at);
      if (n <= 4 * s) begin
        ei = (n - 1) / s;
        if (!busy_v[k] || done_v[k] || idx_v[k] != 2'(ei) ||
            a_v[k] != ei[1] || b_v[k] != ei[0]) seq_err++;
      end
    end
    start_v[k] = 1'b0;
    check($sformatf("vec_seq[k%0d m%0d]", k, mode), seq_err, 0);
    check($sformatf("done_timing[k%0d m%0d]", k, mode), {done_v[k], busy_v[k]}, 2'b10);
    got_exp = exp_q.pop_front();
    check($sformatf("result[k%0d m%0d]", k, mode), res(k), got_exp);
    @(negedge clk);
    check($sformatf("done_pulse_hold[k%0d m%0d]", k, mode),
          {done_v[k], busy_v[k], res(k)}, {2'b00, got_exp});
  endtask

  typedef struct {
    int         k;
    int         mode;
    int         restart_at;
    logic [5:0] exp;       // {pass, xz_seen, fail_mask}
    bit         use_const;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit seen;
    for (int k = 0; k < N; k++) begin
      start_v[k] = 1'b0;
      mode_v[k]  = 3'(M_OR);
    end

    tbl[0] = '{0, M_OR,   0, 6'b10_0000, 1'b0};
    tbl[1] = '{0, M_AND,  0, 6'b00_0110, 1'b0};
    tbl[2] = '{0, M_Z,    0, 6'b01_1111, 1'b1};
    tbl[3] = '{1, M_DLY,  0, 6'b00_0010, 1'b0};
    tbl[4] = '{0, M_DLY,  0, 6'b10_0000, 1'b0};
    tbl[5] = '{0, M_OR,   5, 6'b10_0000, 1'b0};
    tbl[6] = '{2, M_NAND, 0, 6'b10_0000, 1'b0};
    tbl[7] = '{2, M_OR,   0, 6'b00_1001, 1'b0};
    tbl[8] = '{1, M_AND,  3, 6'b00_0110, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) check($sformatf("reset_state[k%0d]", k), all_out(k), 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) check($sformatf("idle_after_reset[k%0d]", k), all_out(k), 0);

    for (int i = 0; i < 9; i++)
      run_sweep(tbl[i].k, tbl[i].mode, tbl[i].restart_at, tbl[i].exp, tbl[i].use_const);

    // start held high: new sweep begins in the IDLE cycle after DONE, results cleared.
    drain(2);
    @(negedge clk);
    mode_v[2] = 3'(M_NAND);
    exp_q.push_back(6'b10_0000);
    start_v[2] = 1'b1;
    repeat (5) @(negedge clk);
    check("held_done", done_v[2], 1'b1);
    check("held_result", res(2), exp_q.pop_front());
    @(negedge clk);
    check("held_idle_gap", {busy_v[2], done_v[2], res(2)}, {2'b00, 6'b10_0000});
    @(negedge clk);
    check("held_restart_cleared", {busy_v[2], res(2)}, {1'b1, 6'b00_0000});
    start_v[2] = 1'b0;
    exp_q.push_back(6'b10_0000);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done_v[2]) seen = 1'b1;
    end
    check("held_second_done", seen, 1'b1);
    check("held_second_result", res(2), exp_q.pop_front());

    // Reset mid-sweep aborts at once and never produces done.
    drain(0);
    @(negedge clk);
    mode_v[0]  = 3'(M_OR);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_abort_busy_idx", {busy_v[0], idx_v[0]}, {1'b1, 2'd1});
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs_zero", all_out(0), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) seen = 1'b1;
    end
    check("no_done_after_abort", seen, 1'b0);
    run_sweep(0, M_OR, 0, 6'b10_0000, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
